// File: rtl/pe_inject_arbiter_pkg.sv
// Shared types and constants for the PE injection arbiter.
// FSM encoding, default widths and the flit-slice helper.
package pe_inject_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int DEF_DATA_W  = 20;
    localparam int DEF_CREDITS = 4;

    function automatic int flit_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin one-hot picker.
// Searches upward from ptr, wrapping modulo N.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    input  logic         en,
    output logic [N-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_inject_arbiter.sv
// Packet-locked round-robin injection arbiter with credit flow control.
// A multi-flit packet holds the grant until its tail flit is accepted.
module pe_inject_arbiter
    import pe_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CREDITS = DEF_CREDITS
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      ci,
    output logic [DATA_W-1:0]         dataout,
    output logic                      out_valid,
    output logic [2:0]                grant_id,
    output logic [2:0]                credit_cnt,
    output logic                      credit_err
);

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);
    localparam logic [2:0] LAST_ID  = 3'(NUM_REQ - 1);

    state_t state, state_nxt;

    logic [2:0]         owner, owner_nxt;
    logic [2:0]         rr_ptr, rr_nxt;
    logic [2:0]         sel, cnt_nxt;
    logic [NUM_REQ-1:0] pick, own_mask;
    logic [DATA_W-1:0]  flits [NUM_REQ];
    logic [DATA_W-1:0]  sel_flit;
    logic               has_credit, xfer, sel_last, err_nxt;

    assign has_credit = (credit_cnt != 3'd0);

    rr_picker #(.N(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (has_credit && !RST && (state == IDLE)),
        .gnt (pick)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_flit
        assign flits[i] = req_data[flit_lsb(i, DATA_W) +: DATA_W];
    end

    always_comb begin
        own_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == 3'(i)) own_mask[i] = 1'b1;
        end
    end

    // In LOCK only the owner may move; everyone else is stalled.
    always_comb begin
        req_ready = '0;
        if (!RST && has_credit) begin
            unique case (state)
                IDLE: req_ready = pick;
                LOCK: req_ready = own_mask & req_valid;
            endcase
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_comb begin
        sel = owner;
        if (state == IDLE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick[i]) sel = 3'(i);
            end
        end
    end

    always_comb begin
        sel_flit = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == 3'(i)) begin
                sel_flit = flits[i];
                sel_last = req_last[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        if (xfer) begin
            if (sel_last) begin
                state_nxt = IDLE;
                rr_nxt    = (sel == LAST_ID) ? 3'd0 : sel + 3'd1;
            end else begin
                state_nxt = LOCK;
                owner_nxt = sel;
            end
        end
    end

    // Credits saturate at both ends; overflow is remembered.
    always_comb begin
        cnt_nxt = credit_cnt;
        err_nxt = credit_err;
        if (xfer && !ci) begin
            cnt_nxt = has_credit ? credit_cnt - 3'd1 : 3'd0;
        end else if (ci && !xfer) begin
            if (credit_cnt >= CRED_MAX) begin
                cnt_nxt = CRED_MAX;
                err_nxt = 1'b1;
            end else begin
                cnt_nxt = credit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= IDLE;
            owner      <= 3'd0;
            rr_ptr     <= 3'd0;
            credit_cnt <= CRED_MAX;
            credit_err <= 1'b0;
            out_valid  <= 1'b0;
            dataout    <= '0;
            grant_id   <= 3'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            rr_ptr     <= rr_nxt;
            credit_cnt <= cnt_nxt;
            credit_err <= err_nxt;
            out_valid  <= xfer;
            if (xfer) begin
                dataout  <= sel_flit;
                grant_id <= sel;
            end
        end
    end

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Directed bench for pe_inject_arbiter.
// Accepted flits are queued and matched against the output stream.
module tb_pe_inject_arbiter;

    localparam int N = 4;
    localparam int W = 20;

    typedef struct packed {
        logic [2:0]   id;
        logic [W-1:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         RST;
    logic [N-1:0] rv, rl, ready;
    logic [N*W-1:0] rd;
    logic         ci;
    logic [W-1:0] dataout;
    logic         out_valid;
    logic [2:0]   grant_id, credit_cnt;
    logic         credit_err;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    pe_inject_arbiter #(.NUM_REQ(N), .DATA_W(W), .CREDITS(4)) dut (
        .clk        (clk),
        .RST        (RST),
        .req_valid  (rv),
        .req_last   (rl),
        .req_data   (rd),
        .req_ready  (ready),
        .ci         (ci),
        .dataout    (dataout),
        .out_valid  (out_valid),
        .grant_id   (grant_id),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_flit(input int i, input logic [W-1:0] v);
        rd[i*W +: W] = v;
    endtask

    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_flit observed=%0h expected=none",
                       dataout);
            end else begin
                mon_e = q.pop_front();
                chk("dataout", 32'(dataout), 32'(mon_e.d));
                chk("grant_id", 32'(grant_id), 32'(mon_e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        rv  = '0;
        rl  = '0;
        rd  = '0;
        ci  = 1'b0;

        // reset state
        @(negedge clk);
        rv = 4'b1111;
        #1 chk("ready_in_rst", 32'(ready), 32'h0);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_credit", 32'(credit_cnt), 32'h4);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_data", 32'(dataout), 32'h0);
        chk("rst_err", 32'(credit_err), 32'h0);

        // single flit from requester 0
        RST = 1'b0;
        rv  = 4'b0001;
        rl  = 4'b0001;
        set_flit(0, 20'h0000A);
        #1 chk("t1_ready", 32'(ready), 32'h1);
        q.push_back('{id: 3'd0, d: 20'h0000A});
        @(negedge clk);
        rv = '0;
        #1 chk("t1_credit", 32'(credit_cnt), 32'h3);
        chk("t1_valid", 32'(out_valid), 32'h1);
        ci = 1'b1;
        @(negedge clk);
        ci = 1'b0;
        chk("t1_credit_back", 32'(credit_cnt), 32'h4);

        // round robin over four single-flit requesters
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        rv  = 4'b1111;
        rl  = 4'b1111;
        for (int i = 0; i < N; i++) set_flit(i, 20'(32'h100 + i));
        for (int k = 0; k < 5; k++) begin
            if (k > 0) ci = 1'b1;
            #1 chk("rr_ready", 32'(ready), 32'(1 << (k % 4)));
            q.push_back('{id: 3'(k % 4), d: 20'(32'h100 + k % 4)});
            if (k > 0) chk("rr_credit", 32'(credit_cnt), 32'h3);
            @(negedge clk);
        end
        rv = '0;
        chk("rr_credit_end", 32'(credit_cnt), 32'h3);
        @(negedge clk);
        ci = 1'b0;
        chk("rr_credit_full", 32'(credit_cnt), 32'h4);

        // 3-flit packet from requester 2 locks out requester 0
        rv = 4'b0101;
        rl = 4'b0001;
        set_flit(2, 20'h00200);
        set_flit(0, 20'h000AA);
        #1 chk("pk_head", 32'(ready), 32'h4);
        q.push_back('{id: 3'd2, d: 20'h00200});
        @(negedge clk);
        set_flit(2, 20'h00201);
        #1 chk("pk_body_lock", 32'(ready), 32'h4);
        q.push_back('{id: 3'd2, d: 20'h00201});
        @(negedge clk);
        set_flit(2, 20'h00202);
        rl = 4'b0101;
        #1 chk("pk_tail_lock", 32'(ready), 32'h4);
        q.push_back('{id: 3'd2, d: 20'h00202});
        @(negedge clk);
        rv = 4'b0011;
        rl = 4'b0011;
        set_flit(1, 20'h00111);
        #1 chk("pk_wrap_to_0", 32'(ready), 32'h1);
        chk("pk_credit", 32'(credit_cnt), 32'h1);
        q.push_back('{id: 3'd0, d: 20'h000AA});
        @(negedge clk);

        // credits exhausted, one ci pulse buys one flit
        rv = 4'b0010;
        #1 chk("cr_zero_ready", 32'(ready), 32'h0);
        chk("cr_zero", 32'(credit_cnt), 32'h0);
        ci = 1'b1;
        @(negedge clk);
        ci = 1'b0;
        #1 chk("cr_one", 32'(credit_cnt), 32'h1);
        chk("cr_one_ready", 32'(ready), 32'h2);
        q.push_back('{id: 3'd1, d: 20'h00111});
        @(negedge clk);
        #1 chk("cr_again_zero", 32'(ready), 32'h0);
        chk("cr_again_cnt", 32'(credit_cnt), 32'h0);
        rv = '0;

        // credit overflow is sticky
        ci = 1'b1;
        repeat (4) @(negedge clk);
        chk("ov_full", 32'(credit_cnt), 32'h4);
        chk("ov_no_err", 32'(credit_err), 32'h0);
        @(negedge clk);
        chk("ov_sat", 32'(credit_cnt), 32'h4);
        chk("ov_err", 32'(credit_err), 32'h1);
        @(negedge clk);
        ci = 1'b0;
        chk("ov_sat2", 32'(credit_cnt), 32'h4);
        @(negedge clk);
        chk("ov_err_held", 32'(credit_err), 32'h1);

        // owner stalls in LOCK, then reset abandons the packet
        rv = 4'b0100;
        rl = 4'b0000;
        set_flit(2, 20'h00300);
        #1 chk("lk_head", 32'(ready), 32'h4);
        q.push_back('{id: 3'd2, d: 20'h00300});
        @(negedge clk);
        rv = 4'b0001;
        rl = 4'b0001;
        set_flit(0, 20'h000BB);
        #1 chk("lk_hold0", 32'(ready[0]), 32'h0);
        @(negedge clk);
        #1 chk("lk_hold1", 32'(ready[0]), 32'h0);
        chk("lk_credit", 32'(credit_cnt), 32'h3);
        RST = 1'b1;
        rv  = 4'b0101;
        rl  = 4'b0000;
        #1 chk("lk_rst_ready", 32'(ready), 32'h0);
        @(negedge clk);
        chk("lk_rst_valid", 32'(out_valid), 32'h0);
        chk("lk_rst_credit", 32'(credit_cnt), 32'h4);
        chk("lk_rst_err", 32'(credit_err), 32'h0);
        RST = 1'b0;
        rv  = 4'b0001;
        rl  = 4'b0001;
        #1 chk("lk_new_winner", 32'(ready), 32'h1);
        q.push_back('{id: 3'd0, d: 20'h000BB});
        @(negedge clk);
        rv = '0;
        @(negedge clk);
        @(negedge clk);
        chk("end_queue_empty", 32'(q.size()), 32'h0);
        chk("end_credit", 32'(credit_cnt), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
